card_shoe: RTL

Card source for the Baccarat datapath. Models a shoe of `NUM_DECKS` standard decks and deals one rank per request on a single-clock handshake. Each dealt rank is encoded 1 (Ace) through 13 (King), with 0 meaning "no card", so the output drives the hand registers and the 7-segment card decoders directly. The shoe tracks the remaining count per rank, never deals a depleted rank, and refills on a shuffle command.

---
 rtl/card_shoe_pkg.sv | 22 ++
 rtl/card_shoe_if.sv | 26 ++
 rtl/card_shoe_rank_ptr.sv | 21 ++
 rtl/card_shoe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/card_shoe_pkg.sv
// Shared types and constants for the card shoe: rank encoding, FSM states
// and the 1..13 wrap helper used by the rank pointer.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_KING = 4'd13;
  localparam int    NUM_RANKS = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } shoe_state_t;

  // Next rank in the circular order Ace..King, King wrapping back to Ace.
  function automatic card_t next_rank(input card_t r);
    return (r == CARD_KING) ? CARD_ACE : card_t'(r + 4'd1);
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/deal bus between a consumer (hand logic or bench) and the shoe.
interface card_shoe_if
  import card_pkg::*;
#(
  parameter int CNT_W = 6
);
  logic             deal_req;
  logic             shuffle;
  card_t            card;
  logic             card_valid;
  logic             busy;
  logic             empty;
  logic [CNT_W-1:0] cards_left;

  // Consumer side: issues requests and shuffles, observes dealt cards.
  modport master (
    output deal_req, shuffle,
    input  card, card_valid, busy, empty, cards_left
  );

  // Shoe side.
  modport slave (
    input  deal_req, shuffle,
    output card, card_valid, busy, empty, cards_left
  );
endinterface

// File: rtl/card_shoe_rank_ptr.sv
// Rank pointer: circular 1..13 counter with an advance enable. Free-runs as
// the randomiser in IDLE and steps past depleted ranks during SCAN.
module rank_ptr
  import card_pkg::*;
(
  input  logic  clk,
  input  logic  resetb,
  input  logic  adv,
  output card_t ptr
);

  // Advance with wrap King -> Ace whenever enabled; starts at Ace.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ptr <= CARD_ACE;
    end else if (adv) begin
      ptr <= next_rank(ptr);
    end
  end

endmodule

// File: rtl/card_shoe.sv
// Card shoe: per-rank remaining counts for NUM_DECKS decks, one card dealt
// per accepted request. The rank is chosen by a free-running pointer, so the
// draw depends on request timing; depleted ranks are skipped in SCAN.
module card_shoe
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1,
  parameter int CNT_W     = $clog2(52*NUM_DECKS+1)
) (
  input  logic        clk,
  input  logic        resetb,
  card_shoe_if.slave  bus
);

  localparam int RANK_MAX = 4 * NUM_DECKS;
  localparam int RW       = $clog2(RANK_MAX + 1);

  localparam logic [RW-1:0]    RANK_FULL = RW'(RANK_MAX);
  localparam logic [CNT_W-1:0] SHOE_FULL = CNT_W'(52 * NUM_DECKS);

  shoe_state_t      state_reg;
  card_t            card_reg;
  logic             card_valid_reg;
  logic [CNT_W-1:0] cards_left_reg;

  card_t            ptr;
  logic [RW-1:0]    count [NUM_RANKS];
  logic [RW-1:0]    count_sel;
  logic             empty_w;
  logic             accept;
  logic             hit;
  logic             ptr_adv;

  assign empty_w = (cards_left_reg == '0);

  // Remaining count of the rank currently under the pointer.
  always_comb begin
    count_sel = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (ptr == card_t'(r + 1)) begin
        count_sel = count[r];
      end
    end
  end

  // Shuffle dominates: it drops a same-edge request and aborts a scan.
  assign accept  = (state_reg == IDLE) && bus.deal_req && !empty_w && !bus.shuffle;
  assign hit     = (state_reg == SCAN) && (count_sel != '0) && !bus.shuffle;
  // Pointer holds on an accepted request, on a hit and on shuffle.
  assign ptr_adv = !bus.shuffle &&
                   (((state_reg == IDLE) && !accept) ||
                    ((state_reg == SCAN) && (count_sel == '0)));

  rank_ptr u_rank_ptr (
    .clk    (clk),
    .resetb (resetb),
    .adv    (ptr_adv),
    .ptr    (ptr)
  );

  // One remaining-count register per rank; hit implies a non-zero count.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
      logic [RW-1:0] cnt_reg;

      // Refill on reset/shuffle, decrement when this rank is dealt.
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          cnt_reg <= RANK_FULL;
        end else if (bus.shuffle) begin
          cnt_reg <= RANK_FULL;
        end else if (hit && (ptr == card_t'(gi + 1))) begin
          cnt_reg <= cnt_reg - RW'(1);
        end
      end

      assign count[gi] = cnt_reg;
    end
  endgenerate

  // Total remaining, kept equal to the sum of the per-rank counts.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cards_left_reg <= SHOE_FULL;
    end else if (bus.shuffle) begin
      cards_left_reg <= SHOE_FULL;
    end else if (hit) begin
      cards_left_reg <= cards_left_reg - CNT_W'(1);
    end
  end

  // Deal FSM with registered card and one-cycle valid pulse.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg      <= IDLE;
      card_reg       <= CARD_NONE;
      card_valid_reg <= 1'b0;
    end else begin
      card_valid_reg <= 1'b0;
      if (bus.shuffle) begin
        state_reg <= IDLE;
        card_reg  <= CARD_NONE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              state_reg <= SCAN;
            end
          end
          SCAN: begin
            if (hit) begin
              card_reg       <= ptr;
              card_valid_reg <= 1'b1;
              state_reg      <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.card       = card_reg;
  assign bus.card_valid = card_valid_reg;
  assign bus.busy       = (state_reg == SCAN);
  assign bus.empty      = empty_w;
  assign bus.cards_left = cards_left_reg;

endmodule
